// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM and its datapath selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_WB_I     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JAL      = 4'd12,
        ST_JR       = 4'd13,
        ST_TRAP     = 4'd14
    } mcState_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU commands
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    // pc source
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_REGA   = 2'd2;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd3;

    // register write address
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // register write data
    localparam logic [1:0] DIN_ALUOUT = 2'd0;
    localparam logic [1:0] DIN_MDR    = 2'd1;
    localparam logic [1:0] DIN_PC     = 2'd2;

    // ALU B operand
    localparam logic [1:0] BSRC_REGB  = 2'd0;
    localparam logic [1:0] BSRC_FOUR  = 2'd1;
    localparam logic [1:0] BSRC_IMM   = 2'd2;
    localparam logic [1:0] BSRC_IMMSH = 2'd3;

    // Instruction dispatch out of DECODE; anything unrecognised traps.
    function automatic mcState_t decodeNext(input logic [5:0] op, input logic [5:0] fn);
        mcState_t nxt;
        nxt = ST_TRAP;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) nxt = ST_EXEC_R;
                else if (fn == FN_JR)                             nxt = ST_JR;
                else                                              nxt = ST_TRAP;
            end
            OP_ADDI, OP_XORI: nxt = ST_EXEC_I;
            OP_LW, OP_SW:     nxt = ST_MEM_ADDR;
            OP_BNE:           nxt = ST_BRANCH;
            OP_J:             nxt = ST_JUMP;
            OP_JAL:           nxt = ST_JAL;
            default:          nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_perf.sv
// Retired-instruction and active-cycle counters for the multicycle core.
// Latency: counts update on the clock edge following the qualifying cycle.
// Backpressure: none; counters free-run and wrap modulo 2^32.
module mc_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cycleEn,
    input  logic        retire,
    output logic [31:0] instrCount,
    output logic [31:0] cycleCount
);

    // Count every non-halted cycle and every retire pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrCount <= '0;
            cycleCount <= '0;
        end else begin
            if (cycleEn) cycleCount <= cycleCount + 32'd1;
            if (retire)  instrCount <= instrCount + 32'd1;
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback; optional counters under MC_CTRL_PERF_EN.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle; outputs decode from the state register.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with request/address/write stable until memReady.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        aluZero,
    input  logic        memReady,
    output logic        memReq,
    output logic        memWe,
    output logic        iOrD,
    output logic        irWe,
    output logic        pcWe,
    output logic [1:0]  pcSrcCtrl,
    output logic        regWe,
    output logic [1:0]  regDst,
    output logic [1:0]  regDInCtrl,
    output logic        aluASrc,
    output logic [1:0]  aluBSrc,
    output logic [2:0]  aluOp,
    output logic        halt,
    output logic [31:0] instrCount,
    output logic [31:0] cycleCount
);

    mcState_t state;

    // State register; reset lands in FETCH so the first fetch request is already up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:    if (memReady) state <= ST_DECODE;
                ST_DECODE:   state <= decodeNext(opcode, funct);
                ST_EXEC_R:   state <= ST_WB_R;
                ST_EXEC_I:   state <= ST_WB_I;
                ST_MEM_ADDR: state <= (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD:   if (memReady) state <= ST_MEM_WB;
                ST_MEM_WR:   if (memReady) state <= ST_FETCH;
                ST_MEM_WB, ST_WB_R, ST_WB_I, ST_BRANCH,
                ST_JUMP, ST_JAL, ST_JR: state <= ST_FETCH;
                ST_TRAP:     state <= ST_TRAP;
                default:     state <= ST_TRAP;
            endcase
        end
    end

    // Output decode from state; memReady only gates the FETCH loads.
    always_comb begin
        memReq     = 1'b0;
        memWe      = 1'b0;
        iOrD       = 1'b0;
        irWe       = 1'b0;
        pcWe       = 1'b0;
        pcSrcCtrl  = PCSRC_ALU;
        regWe      = 1'b0;
        regDst     = REGDST_RT;
        regDInCtrl = DIN_ALUOUT;
        aluASrc    = 1'b0;
        aluBSrc    = BSRC_REGB;
        aluOp      = ALU_ADD;
        halt       = 1'b0;
        case (state)
            ST_FETCH: begin
                memReq  = 1'b1;
                aluBSrc = BSRC_FOUR;
                irWe    = memReady;
                pcWe    = memReady;
            end
            ST_DECODE: aluBSrc = BSRC_IMMSH;
            ST_EXEC_R: begin
                aluASrc = 1'b1;
                case (funct)
                    FN_SUB:  aluOp = ALU_SUB;
                    FN_SLT:  aluOp = ALU_SLT;
                    default: aluOp = ALU_ADD;
                endcase
            end
            ST_WB_R: begin
                regWe  = 1'b1;
                regDst = REGDST_RD;
            end
            ST_EXEC_I: begin
                aluASrc = 1'b1;
                aluBSrc = BSRC_IMM;
                aluOp   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            ST_WB_I: regWe = 1'b1;
            ST_MEM_ADDR: begin
                aluASrc = 1'b1;
                aluBSrc = BSRC_IMM;
            end
            ST_MEM_RD: begin
                memReq = 1'b1;
                iOrD   = 1'b1;
            end
            ST_MEM_WR: begin
                memReq = 1'b1;
                memWe  = 1'b1;
                iOrD   = 1'b1;
            end
            ST_MEM_WB: begin
                regWe      = 1'b1;
                regDInCtrl = DIN_MDR;
            end
            ST_BRANCH: begin
                aluASrc   = 1'b1;
                aluOp     = ALU_SUB;
                pcWe      = !aluZero;
                pcSrcCtrl = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pcWe      = 1'b1;
                pcSrcCtrl = PCSRC_JUMP;
            end
            ST_JAL: begin
                regWe      = 1'b1;
                regDst     = REGDST_RA;
                regDInCtrl = DIN_PC;
                pcWe       = 1'b1;
                pcSrcCtrl  = PCSRC_JUMP;
            end
            ST_JR: begin
                pcWe      = 1'b1;
                pcSrcCtrl = PCSRC_REGA;
            end
            ST_TRAP: begin
                halt      = 1'b1;
                pcSrcCtrl = RESET_PC_SEL;
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic retire;
    logic cycleEn;

    // One retire pulse per instruction: its final state, or the completing MEM_WR cycle.
    assign retire = (state == ST_WB_R) || (state == ST_WB_I) || (state == ST_MEM_WB) ||
                    (state == ST_BRANCH) || (state == ST_JUMP) || (state == ST_JAL) ||
                    (state == ST_JR) || ((state == ST_MEM_WR) && memReady);
    assign cycleEn = (state != ST_TRAP);

    mc_perf u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .cycleEn    (cycleEn),
        .retire     (retire),
        .instrCount (instrCount),
        .cycleCount (cycleCount)
    );
`else
    assign instrCount = '0;
    assign cycleCount = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its state sequence.
// Latency: checks land 2 time units after each rising edge.
// Backpressure: exercises memReady waits in FETCH, MEM_RD and MEM_WR.
module tb_mc_ctrl;

`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        aluZero;
    logic        memReady;
    logic        memReq, memWe, iOrD, irWe, pcWe, regWe, aluASrc, halt;
    logic [1:0]  pcSrcCtrl, regDst, regDInCtrl, aluBSrc;
    logic [2:0]  aluOp;
    logic [31:0] instrCount, cycleCount;

    int errors = 0;
    int checks = 0;
    int expCyc = 0;
    int expInstr = 0;
    bit inTrap = 1'b0;

    logic [18:0] ctl;
    logic [18:0] fetchRdy, fetchWait, decodeC, wbR, wbI, memAddr, memRd, memWr, memWb;
    logic [18:0] jumpC, jalC, jrC, trapC;

    mc_ctrl #(.RESET_PC_SEL(2'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .aluZero    (aluZero),
        .memReady   (memReady),
        .memReq     (memReq),
        .memWe      (memWe),
        .iOrD       (iOrD),
        .irWe       (irWe),
        .pcWe       (pcWe),
        .pcSrcCtrl  (pcSrcCtrl),
        .regWe      (regWe),
        .regDst     (regDst),
        .regDInCtrl (regDInCtrl),
        .aluASrc    (aluASrc),
        .aluBSrc    (aluBSrc),
        .aluOp      (aluOp),
        .halt       (halt),
        .instrCount (instrCount),
        .cycleCount (cycleCount)
    );

    always #5 clk = ~clk;

    assign ctl = {memReq, memWe, iOrD, irWe, pcWe, pcSrcCtrl, regWe, regDst,
                  regDInCtrl, aluASrc, aluBSrc, aluOp, halt};

    function automatic logic [18:0] mk(input logic rq, input logic we, input logic iod,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic rw, input logic [1:0] rd, input logic [1:0] din,
                                       input logic asrc, input logic [1:0] bsrc,
                                       input logic [2:0] op, input logic h);
        return {rq, we, iod, irw, pcw, pcs, rw, rd, din, asrc, bsrc, op, h};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Let inputs settle, then compare the whole control bundle.
    task automatic chkCtl(input string tag, input logic [18:0] exp);
        #1;
        chk(tag, {13'd0, ctl}, {13'd0, exp});
    endtask

    task automatic chkCnt(input string tag);
        chk({tag, "_instr"}, instrCount, PERF ? 32'(expInstr) : 32'd0);
        chk({tag, "_cyc"},   cycleCount, PERF ? 32'(expCyc)   : 32'd0);
    endtask

    // Advance one clock; model the counters for the cycle just finished.
    task automatic tick(input bit ret);
        @(posedge clk);
        if (!inTrap) expCyc++;
        if (ret)     expInstr++;
        #1;
    endtask

    initial begin
        fetchRdy  = mk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0);
        fetchWait = mk(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0);
        decodeC   = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0);
        wbR       = mk(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0,3'd0,0);
        wbI       = mk(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd0,3'd0,0);
        memAddr   = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd0,0);
        memRd     = mk(1,0,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0);
        memWr     = mk(1,1,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0);
        memWb     = mk(0,0,0,0,0,2'd0,1,2'd0,2'd1,0,2'd0,3'd0,0);
        jumpC     = mk(0,0,0,0,1,2'd1,0,2'd0,2'd0,0,2'd0,3'd0,0);
        jalC      = mk(0,0,0,0,1,2'd1,1,2'd2,2'd2,0,2'd0,3'd0,0);
        jrC       = mk(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,2'd0,3'd0,0);
        trapC     = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,1);

        // Reset: FETCH with only the request and PC+4 operands up.
        rst_n = 1'b0; memReady = 1'b0; opcode = 6'h00; funct = 6'h20; aluZero = 1'b0;
        #2;
        chkCtl("reset_fetch", fetchWait);
        chkCnt("reset");
        #8;
        rst_n = 1'b1;

        // ADD: FETCH, DECODE, EXEC_R, WB_R
        memReady = 1'b1;
        chkCtl("add_fetch", fetchRdy);        tick(0);
        chkCtl("add_decode", decodeC);        tick(0);
        chkCtl("add_exec", mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0,3'd0,0)); tick(0);
        chkCtl("add_wb", wbR);                tick(1);
        chkCnt("add_done");

        // SUB with one FETCH wait cycle
        funct = 6'h22; memReady = 1'b0;
        chkCtl("sub_fetch_wait", fetchWait);  tick(0);
        memReady = 1'b1;
        chkCtl("sub_fetch", fetchRdy);        tick(0);
        chkCtl("sub_decode", decodeC);        tick(0);
        chkCtl("sub_exec", mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0,3'd1,0)); tick(0);
        chkCtl("sub_wb", wbR);                tick(1);

        // SLT
        funct = 6'h2A;
        chkCtl("slt_fetch", fetchRdy);        tick(0);
        chkCtl("slt_decode", decodeC);        tick(0);
        chkCtl("slt_exec", mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0,3'd3,0)); tick(0);
        chkCtl("slt_wb", wbR);                tick(1);

        // ADDI, XORI
        opcode = 6'h08;
        chkCtl("addi_fetch", fetchRdy);       tick(0);
        chkCtl("addi_decode", decodeC);       tick(0);
        chkCtl("addi_exec", mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd0,0)); tick(0);
        chkCtl("addi_wb", wbI);               tick(1);
        opcode = 6'h0E;
        chkCtl("xori_fetch", fetchRdy);       tick(0);
        chkCtl("xori_decode", decodeC);       tick(0);
        chkCtl("xori_exec", mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd2,0)); tick(0);
        chkCtl("xori_wb", wbI);               tick(1);
        chkCnt("alu_done");

        // LW with two wait cycles in MEM_RD: 7 cycles total
        opcode = 6'h23;
        chkCtl("lw_fetch", fetchRdy);         tick(0);
        chkCtl("lw_decode", decodeC);         tick(0);
        chkCtl("lw_addr", memAddr);           tick(0);
        memReady = 1'b0;
        chkCtl("lw_rd_wait0", memRd);         tick(0);
        chkCtl("lw_rd_wait1", memRd);         tick(0);
        memReady = 1'b1;
        chkCtl("lw_rd_done", memRd);          tick(0);
        chkCtl("lw_wb", memWb);               tick(1);
        chkCnt("lw_done");

        // SW, memReady tied high: 4 cycles
        opcode = 6'h2B;
        chkCtl("sw_fetch", fetchRdy);         tick(0);
        chkCtl("sw_decode", decodeC);         tick(0);
        chkCtl("sw_addr", memAddr);           tick(0);
        chkCtl("sw_wr", memWr);               tick(1);
        chkCnt("sw_done");

        // BNE taken-not (aluZero=1) and taken (aluZero=0)
        opcode = 6'h05; aluZero = 1'b1;
        chkCtl("bne_eq_fetch", fetchRdy);     tick(0);
        chkCtl("bne_eq_decode", decodeC);     tick(0);
        chkCtl("bne_eq_branch", mk(0,0,0,0,0,2'd3,0,2'd0,2'd0,1,2'd0,3'd1,0)); tick(1);
        aluZero = 1'b0;
        chkCtl("bne_ne_fetch", fetchRdy);     tick(0);
        chkCtl("bne_ne_decode", decodeC);     tick(0);
        chkCtl("bne_ne_branch", mk(0,0,0,0,1,2'd3,0,2'd0,2'd0,1,2'd0,3'd1,0)); tick(1);

        // J, JAL, JR
        opcode = 6'h02;
        chkCtl("j_fetch", fetchRdy);          tick(0);
        chkCtl("j_decode", decodeC);          tick(0);
        chkCtl("j_jump", jumpC);              tick(1);
        opcode = 6'h03;
        chkCtl("jal_fetch", fetchRdy);        tick(0);
        chkCtl("jal_decode", decodeC);        tick(0);
        chkCtl("jal_jal", jalC);              tick(1);
        opcode = 6'h00; funct = 6'h08;
        chkCtl("jr_fetch", fetchRdy);         tick(0);
        chkCtl("jr_decode", decodeC);         tick(0);
        chkCtl("jr_jr", jrC);                 tick(1);
        chkCnt("jump_done");

        // Reset in the middle of a stalled MEM_WR kills memWe at once
        opcode = 6'h2B; funct = 6'h20;
        chkCtl("swr_fetch", fetchRdy);        tick(0);
        chkCtl("swr_decode", decodeC);        tick(0);
        chkCtl("swr_addr", memAddr);          tick(0);
        memReady = 1'b0;
        chkCtl("swr_wr_wait", memWr);
        rst_n = 1'b0; expCyc = 0; expInstr = 0;
        chkCtl("swr_reset_fetch", fetchWait);
        chk("swr_reset_memWe", {31'd0, memWe}, 32'd0);
        chkCnt("swr_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Illegal opcode traps; counters freeze; reset recovers
        opcode = 6'h3F; memReady = 1'b1;
        chkCtl("trap_fetch", fetchRdy);       tick(0);
        chkCtl("trap_decode", decodeC);       tick(0);
        inTrap = 1'b1;
        chkCtl("trap_enter", trapC);          tick(0);
        chkCtl("trap_hold", trapC);           tick(0);
        tick(0);
        chkCnt("trap_frozen");
        rst_n = 1'b0; expCyc = 0; expInstr = 0; inTrap = 1'b0;
        chkCtl("trap_reset_fetch", fetchRdy);
        chk("trap_reset_halt", {31'd0, halt}, 32'd0);
        chkCnt("trap_reset");
        @(negedge clk);
        rst_n = 1'b1;
        opcode = 6'h00; funct = 6'h20;
        #1;
        chkCtl("post_reset_fetch", fetchRdy); tick(0);
        chkCtl("post_reset_decode", decodeC);
        chkCnt("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
